sum_accum: RTL and testbench



---
 rtl/sum_accum_pkg.sv | 19 +
 rtl/sum_accum_if.sv | 30 +++
 rtl/sum_accum_dp.sv | 54 +++++
 rtl/sum_accum.sv | 91 +++++++++
 tb/tb_sum_accum.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/sum_accum_pkg.sv
// Shared types and default widths for the sum_accum frame accumulator.
package sum_accum_pkg;

  localparam int N_DEF     = 10;
  localparam int CNT_W_DEF = 8;
  localparam int ACC_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Smallest accumulator that can never carry out for a full-length frame.
  function automatic int min_safe_acc_w(input int n, input int cnt_w);
    return n + 1 + cnt_w;
  endfunction

endpackage

// File: rtl/sum_accum_if.sv
// Frame-control, beat-input and result handshake bundle for sum_accum.
interface sum_accum_if
  import sum_accum_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ACC_W = ACC_W_DEF
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [N:0]       in_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             ovf;
  logic             busy;

  modport master (
    output start, len, in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_acc, out_count, ovf, busy
  );

  modport slave (
    input  start, len, in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_acc, out_count, ovf, busy
  );
endinterface

// File: rtl/sum_accum_dp.sv
// Accumulator datapath: ACC_W+1-bit add, sticky carry flag, optional clamp.
// SUM_ACCUM_SAT_EN: clamp to all-ones on carry instead of wrapping.
module sum_accum_dp
  import sum_accum_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             add_en,
  input  logic [N:0]       in_sum,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc_q} + (ACC_W+1)'(in_sum);

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clear) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (add_en) begin
      ovf_d = ovf_q | sum[ACC_W];
`ifdef SUM_ACCUM_SAT_EN
      // Once clamped, any further add carries again, so the clamp holds.
      acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
      acc_d = sum[ACC_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/sum_accum.sv
// Frame accumulator behind adder_nbit: sums len beats, presents total on a handshake.
// SUM_ACCUM_SAT_EN selects saturating accumulation (default: wrap, ovf flags it).
module sum_accum
  import sum_accum_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  sum_accum_if.slave    io
);

  if (ACC_W < N + 1) begin : g_acc_w_chk
    $error("sum_accum: ACC_W must be >= N+1");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             beat, load, clear, add_en;

  assign io.in_ready  = (state_q == ACCUM);
  assign io.out_valid = (state_q == DONE);
  assign io.busy      = (state_q != IDLE);

  assign beat    = io.in_valid && io.in_ready;
  assign cnt_inc = cnt_q + CNT_W'(1);
  // A new frame may open from IDLE or on the very cycle the result is taken.
  assign load    = io.start && (io.len != '0) &&
                   ((state_q == IDLE) || ((state_q == DONE) && io.out_ready));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    clear   = 1'b0;
    add_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) state_d = ACCUM;
      end
      ACCUM: begin
        if (beat) begin
          add_en = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_inc == len_q) state_d = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) state_d = load ? ACCUM : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      len_d = io.len;
      cnt_d = '0;
      clear = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  sum_accum_dp #(
    .N     (N),
    .ACC_W (ACC_W)
  ) u_dp (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .add_en (add_en),
    .in_sum (io.in_sum),
    .acc    (io.out_acc),
    .ovf    (io.ovf)
  );

  assign io.out_count = cnt_q;

endmodule

// File: tb/tb_sum_accum.sv
// Directed bench for sum_accum (N=10, CNT_W=8, ACC_W=16), hand-computed expectations.
module tb_sum_accum;
  import sum_accum_pkg::*;

  localparam int N     = 10;
  localparam int CNT_W = 8;
  localparam int ACC_W = 16;
`ifdef SUM_ACCUM_SAT_EN
  localparam int BIG_EXP = 65535;
`else
  localparam int BIG_EXP = 16304;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  sum_accum_if #(.N(N), .CNT_W(CNT_W), .ACC_W(ACC_W)) io ();

  sum_accum #(.N(N), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int acc, input int cnt, input int o);
    chk({tag, ".out_valid"}, 32'(io.out_valid), 1);
    chk({tag, ".in_ready"},  32'(io.in_ready), 0);
    chk({tag, ".out_acc"},   32'(io.out_acc), 32'(acc));
    chk({tag, ".out_count"}, 32'(io.out_count), 32'(cnt));
    chk({tag, ".ovf"},       32'(io.ovf), 32'(o));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".out_valid"}, 32'(io.out_valid), 0);
    chk({tag, ".in_ready"},  32'(io.in_ready), 0);
    chk({tag, ".busy"},      32'(io.busy), 0);
    chk({tag, ".out_acc"},   32'(io.out_acc), 0);
    chk({tag, ".out_count"}, 32'(io.out_count), 0);
    chk({tag, ".ovf"},       32'(io.ovf), 0);
  endtask

  task automatic start_frame(input int l);
    io.start = 1'b1;
    io.len   = CNT_W'(l);
    tick();
    io.start = 1'b0;
  endtask

  task automatic beat(input int v);
    io.in_valid = 1'b1;
    io.in_sum   = (N+1)'(v);
    tick();
    io.in_valid = 1'b0;
  endtask

  task automatic take_result(input string tag);
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    chk({tag, ".busy_after_take"}, 32'(io.busy), 0);
    chk({tag, ".ov_after_take"},   32'(io.out_valid), 0);
  endtask

  initial begin
    io.start = 1'b0; io.len = '0; io.in_valid = 1'b0; io.in_sum = '0; io.out_ready = 1'b0;

    // Reset state
    tick(); tick();
    chk_reset("rst");
    rst = 1'b0;
    tick();

    // Frame of 3 with a 2-cycle gap
    start_frame(3);
    chk("f3.busy", 32'(io.busy), 1);
    chk("f3.in_ready", 32'(io.in_ready), 1);
    beat(14);
    chk("f3.acc1", 32'(io.out_acc), 14);
    tick(); tick();
    chk("f3.gap_acc", 32'(io.out_acc), 14);
    chk("f3.gap_cnt", 32'(io.out_count), 1);
    beat(99);
    chk("f3.ov_before_last", 32'(io.out_valid), 0);
    beat(147);
    chk_out("f3", 260, 3, 0);
    take_result("f3");

    // Single-beat frame at max in_sum
    start_frame(1);
    beat(2046);
    chk_out("f1", 2046, 1, 0);
    take_result("f1");

    // 40 x 2046: carry appears on beat 33
    start_frame(40);
    for (int i = 0; i < 32; i++) beat(2046);
    chk("f40.acc32", 32'(io.out_acc), 65472);
    chk("f40.ovf32", 32'(io.ovf), 0);
    for (int i = 0; i < 8; i++) beat(2046);
    chk_out("f40", BIG_EXP, 40, 1);

    // Stall in DONE: inputs poked, nothing may move
    io.in_valid = 1'b1; io.in_sum = 11'd7; io.start = 1'b1; io.len = 8'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("stall", BIG_EXP, 40, 1);
    end
    io.in_valid = 1'b0;

    // Back-to-back frame opened on the handshake cycle
    io.out_ready = 1'b1; io.start = 1'b1; io.len = 8'd2;
    tick();
    io.out_ready = 1'b0; io.start = 1'b0;
    chk("b2b.in_ready", 32'(io.in_ready), 1);
    chk("b2b.out_valid", 32'(io.out_valid), 0);
    chk("b2b.acc_clr", 32'(io.out_acc), 0);
    chk("b2b.ovf_clr", 32'(io.ovf), 0);
    beat(1);
    beat(2);
    chk_out("b2b", 3, 2, 0);
    take_result("b2b");

    // Reset mid-frame
    start_frame(4);
    beat(10);
    beat(20);
    rst = 1'b1;
    tick();
    chk_reset("midrst");
    rst = 1'b0;
    start_frame(1);
    beat(5);
    chk_out("post_rst", 5, 1, 0);
    take_result("post_rst");

    // len==0 is ignored; in_valid in IDLE has no effect
    start_frame(0);
    chk("len0.busy", 32'(io.busy), 0);
    chk("len0.in_ready", 32'(io.in_ready), 0);
    beat(9);
    chk("idle_beat.busy", 32'(io.busy), 0);
    start_frame(1);
    beat(4);
    chk_out("idle_beat", 4, 1, 0);
    take_result("idle_beat");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
